// File: rtl/inst_issue_queue.sv
// Dual-lane show-ahead instruction queue between decode and issue: 0-2 pushes, 0-2 pops per cycle.
// Pushed entries are visible one cycle later; stall freezes all state, and flush empties the queue.
module inst_issue_queue #(
  parameter int DEPTH      = 16,
  parameter int OVF_MARGIN = 4,
  parameter int INST_W     = 32,
  parameter int PC_W       = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       stall,
  input  logic [1:0]                 in_valid,
  input  logic [INST_W-1:0]          in_inst0,
  input  logic [PC_W-1:0]            in_pc0,
  input  logic [INST_W-1:0]          in_inst1,
  input  logic [PC_W-1:0]            in_pc1,
  input  logic [1:0]                 pop_cnt,
  output logic [1:0]                 out_valid,
  output logic [INST_W-1:0]          out_inst0,
  output logic [PC_W-1:0]            out_pc0,
  output logic [INST_W-1:0]          out_inst1,
  output logic [PC_W-1:0]            out_pc1,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       drop_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [INST_W-1:0] inst_q [DEPTH];
  logic [PC_W-1:0]   pc_q   [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] head_p1, tail_p1;
  logic [CW-1:0] count_q, count_d;
  logic          drop_err_q, drop_err_d;

  logic [1:0]    pop_req, pops, push_req, push_acc;
  logic [CW:0]   free_slots;
  logic          illegal, wr0, wr1;

  assign head_p1 = head_q + PW'(1);
  assign tail_p1 = tail_q + PW'(1);

  always_comb begin
    pop_req    = (pop_cnt > 2'd2) ? 2'd2 : pop_cnt;
    pops       = 2'd0;
    push_req   = 2'd0;
    push_acc   = 2'd0;
    drop_err_d = 1'b0;
    illegal    = (in_valid == 2'b10);

    // Pops are judged against start-of-cycle occupancy, so no same-cycle bypass.
    if (!stall) begin
      pops = (count_q < CW'(pop_req)) ? count_q[1:0] : pop_req;
    end

    if (!illegal) begin
      push_req = {1'b0, in_valid[0]} + {1'b0, in_valid[1]};
    end

    free_slots = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pops);

    if (!stall && !flush) begin
      push_acc   = ((CW+1)'(push_req) > free_slots) ? free_slots[1:0] : push_req;
      drop_err_d = illegal || ((CW+1)'(push_req) > free_slots);
    end

    wr0 = (push_acc >= 2'd1);
    wr1 = (push_acc == 2'd2);

    head_d  = head_q + PW'(pops);
    tail_d  = tail_q + PW'(push_acc);
    count_d = count_q + CW'(push_acc) - CW'(pops);

    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      drop_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drop_err_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Entry storage carries no reset; validity is tracked purely by count_q.
  always_ff @(posedge clk) begin
    if (wr0) begin
      inst_q[tail_q] <= in_inst0;
      pc_q[tail_q]   <= in_pc0;
    end
    if (wr1) begin
      inst_q[tail_p1] <= in_inst1;
      pc_q[tail_p1]   <= in_pc1;
    end
  end

  assign out_valid = {(count_q >= CW'(2)), (count_q >= CW'(1))};
  assign out_inst0 = inst_q[head_q];
  assign out_pc0   = pc_q[head_q];
  assign out_inst1 = inst_q[head_p1];
  assign out_pc1   = pc_q[head_p1];
  assign count     = count_q;
  assign overflow  = (((CW+1)'(DEPTH) - {1'b0, count_q}) < (CW+1)'(OVF_MARGIN));
  assign drop_err  = drop_err_q;

  a_count_bound: assert property (@(posedge clk) disable iff (reset) count_q <= CW'(DEPTH));
  a_ptr_count:   assert property (@(posedge clk) disable iff (reset)
                                  (tail_q - head_q) == count_q[PW-1:0]);

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue: a scoreboard tracks accepted PCs, a monitor checks popped data.
module tb_inst_issue_queue;

  logic        clk = 1'b0;
  logic        reset, flush, stall;
  logic [1:0]  in_valid, pop_cnt;
  logic [31:0] in_inst0, in_pc0, in_inst1, in_pc1;
  logic [1:0]  out_valid;
  logic [31:0] out_inst0, out_pc0, out_inst1, out_pc1;
  logic [4:0]  count;
  logic        overflow, drop_err;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pc_nx = 32'h100;

  inst_issue_queue #(.DEPTH(16), .OVF_MARGIN(4), .INST_W(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_inst0(in_inst0), .in_pc0(in_pc0),
    .in_inst1(in_inst1), .in_pc1(in_pc1), .pop_cnt(pop_cnt),
    .out_valid(out_valid), .out_inst0(out_inst0), .out_pc0(out_pc0),
    .out_inst1(out_inst1), .out_pc1(out_pc1), .count(count),
    .overflow(overflow), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: on every cycle where issue actually consumes a lane, compare it with the scoreboard.
  always @(negedge clk) begin
    if (!reset && !flush && !stall) begin
      for (int k = 0; k < 2; k++) begin
        if (out_valid[k] && (int'(pop_cnt) > k)) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected lane%0d: got pc 0x%0h expected no entry", k, k == 0 ? out_pc0 : out_pc1);
          end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check(k == 0 ? "pop_pc0" : "pop_pc1", k == 0 ? out_pc0 : out_pc1, e);
            check(k == 0 ? "pop_inst0" : "pop_inst1", k == 0 ? out_inst0 : out_inst1, inst_of(e));
          end
        end
      end
    end
  end

  // One cycle of stimulus; acc is the hand-computed number of lanes the queue should accept.
  task automatic cyc(input logic [1:0] iv, input logic [1:0] pc_n,
                     input logic stl, input logic fl, input int acc);
    in_valid = iv;
    in_pc0   = pc_nx;
    in_pc1   = pc_nx + 32'd4;
    in_inst0 = inst_of(in_pc0);
    in_inst1 = inst_of(in_pc1);
    pop_cnt  = pc_n;
    stall    = stl;
    flush    = fl;
    if (fl) exp_q.delete();
    if (acc >= 1) exp_q.push_back(in_pc0);
    if (acc >= 2) exp_q.push_back(in_pc1);
    if (iv == 2'b11) pc_nx = pc_nx + 32'd8;
    else if (iv == 2'b01) pc_nx = pc_nx + 32'd4;
    @(posedge clk);
    #1;
    in_valid = 2'b00;
    pop_cnt  = 2'd0;
    stall    = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0;
    in_valid = 2'b00; pop_cnt = 2'd0;
    in_inst0 = '0; in_pc0 = '0; in_inst1 = '0; in_pc1 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);

    // First dual push: visible next cycle.
    cyc(2'b11, 2'd0, 1'b0, 1'b0, 2);
    check("t1_out_valid", 32'(out_valid), 32'd3);
    check("t1_out_pc0", out_pc0, 32'h100);
    check("t1_out_pc1", out_pc1, 32'h104);
    check("t1_count", 32'(count), 32'd2);

    // Overflow threshold: count 12 -> 0, count 13 -> 1, back to 11 -> 0.
    repeat (5) cyc(2'b11, 2'd0, 1'b0, 1'b0, 2);
    check("t2_count12", 32'(count), 32'd12);
    check("t2_ovf_at12", 32'(overflow), 32'd0);
    cyc(2'b01, 2'd0, 1'b0, 1'b0, 1);
    check("t2_count13", 32'(count), 32'd13);
    check("t2_ovf_at13", 32'(overflow), 32'd1);
    cyc(2'b00, 2'd2, 1'b0, 1'b0, 0);
    check("t2_count11", 32'(count), 32'd11);
    check("t2_ovf_at11", 32'(overflow), 32'd0);

    // Capacity edge: one free slot drops lane1; a same-cycle pop frees room for both.
    repeat (2) cyc(2'b11, 2'd0, 1'b0, 1'b0, 2);
    check("t3_count15", 32'(count), 32'd15);
    cyc(2'b11, 2'd0, 1'b0, 1'b0, 1);
    check("t3_count_full", 32'(count), 32'd16);
    check("t3_drop_err", 32'(drop_err), 32'd1);
    check("t3_ovf_full", 32'(overflow), 32'd1);
    cyc(2'b00, 2'd1, 1'b0, 1'b0, 0);
    check("t3_count_back15", 32'(count), 32'd15);
    check("t3_drop_clear", 32'(drop_err), 32'd0);
    cyc(2'b11, 2'd1, 1'b0, 1'b0, 2);
    check("t3_count_full2", 32'(count), 32'd16);
    check("t3_no_drop", 32'(drop_err), 32'd0);

    // Drain to 8, then steady push2/pop2 across many pointer wraps.
    repeat (4) cyc(2'b00, 2'd2, 1'b0, 1'b0, 0);
    check("t4_count8", 32'(count), 32'd8);
    for (int i = 0; i < 40; i++) begin
      cyc(2'b11, 2'd2, 1'b0, 1'b0, 2);
      check("t4_count_const", 32'(count), 32'd8);
    end

    // Flush outranks stall, push and pop.
    cyc(2'b00, 2'd2, 1'b0, 1'b0, 0);
    cyc(2'b00, 2'd1, 1'b0, 1'b0, 0);
    check("t5_count5", 32'(count), 32'd5);
    cyc(2'b11, 2'd2, 1'b1, 1'b1, 0);
    check("t5_count0", 32'(count), 32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_drop_err", 32'(drop_err), 32'd0);

    // Stall freezes everything; then an illegal lane pattern is dropped.
    repeat (2) cyc(2'b11, 2'd0, 1'b0, 1'b0, 2);
    check("t6_count4", 32'(count), 32'd4);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b11, 2'd2, 1'b1, 1'b0, 0);
      check("t6_stall_count", 32'(count), 32'd4);
      check("t6_stall_valid", 32'(out_valid), 32'd3);
      check("t6_stall_pc0", out_pc0, exp_q[0]);
      check("t6_stall_pc1", out_pc1, exp_q[1]);
      check("t6_stall_drop", 32'(drop_err), 32'd0);
    end
    cyc(2'b10, 2'd0, 1'b0, 1'b0, 0);
    check("t6_illegal_count", 32'(count), 32'd4);
    check("t6_illegal_drop", 32'(drop_err), 32'd1);
    cyc(2'b00, 2'd0, 1'b0, 1'b0, 0);
    check("t6_drop_pulse_end", 32'(drop_err), 32'd0);
    repeat (2) cyc(2'b00, 2'd2, 1'b0, 1'b0, 0);
    check("end_count", 32'(count), 32'd0);
    check("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
